// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks.
//   - parity mode encodings carried on i_Parity_Mode
//   - transmitter state encoding
//   - parity_bit(): parity helper shared by the TX and (future) RX blocks
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  // Widest data word any UART block supports; narrower words are zero-extended,
  // which leaves their XOR reduction unchanged.
  localparam int PAR_MAX_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Parity bit for a zero-extended data word under the given mode.
  function automatic logic parity_bit(input logic [PAR_MAX_BITS-1:0] data,
                                      input logic [1:0]              mode);
    logic p;
    case (mode)
      PAR_ODD:  p = ~^data;
      PAR_EVEN: p = ^data;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period timer shared by the UART TX and RX blocks.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of every bit period.
// Ports:
//   clk       in  clock
//   reset_n   in  asynchronous active-low reset
//   i_Clear   in  hold the count at 0 (next bit period starts at count 0)
//   o_Bit_End out high during the last cycle of each bit period (registered)
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_Clear,
  output logic o_Bit_End
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             bit_end_r;

  // Next count: clear, wrap at terminal count, or increment.
  always_comb begin
    cnt_s = cnt_r;
    if (i_Clear) begin
      cnt_s = '0;
    end else if (cnt_r == LAST_CNT) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + 1'b1;
    end
  end

  // Count register; bit_end is registered by decoding the next count so it
  // lines up with the cycle in which cnt_r sits at terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= '0;
      bit_end_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      bit_end_r <= (cnt_s == LAST_CNT);
    end
  end

  assign o_Bit_End = bit_end_r;

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with valid/ready word handshake.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Ports:
//   clk           in  clock
//   reset_n       in  asynchronous active-low reset
//   i_Tx_Byte     in  data word, bit 0 sent first
//   i_Tx_Valid    in  word available
//   i_Parity_Mode in  00 none, 01 odd, 10 even, 11 mark
//   o_Tx_Ready    out block accepts a word this cycle
//   o_Tx_Active   out a frame is on the line
//   o_Tx_Done     out one-cycle pulse when a frame completes
//   o_Tx_Data     out serial line, idles high
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  input  logic                 i_Tx_Valid,
  input  logic [1:0]           i_Parity_Mode,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done,
  output logic                 o_Tx_Data
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  tx_state_e              state_r, state_s;
  logic [DATA_BITS-1:0]   shift_r, shift_s;
  logic [IDX_W-1:0]       idx_r, idx_s;
  logic                   stop_cnt_r, stop_cnt_s;
  logic                   par_en_r, par_en_s;
  logic                   par_bit_r, par_bit_s;
  logic                   tx_data_r, tx_data_s;
  logic                   ready_r, ready_s;
  logic                   active_r, active_s;
  logic                   done_r, done_s;
  logic [PAR_MAX_BITS-1:0] word_ext_s;
  logic                   clear_s;
  logic                   bit_end_s;

  // Baud timer is held at 0 while idle, so the first start-bit cycle after
  // the accept edge is count 0.
  assign clear_s = (state_r == ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_Clear  (clear_s),
    .o_Bit_End(bit_end_s)
  );

  // Zero-extend the incoming word for the shared parity helper.
  always_comb begin
    word_ext_s                = '0;
    word_ext_s[DATA_BITS-1:0] = i_Tx_Byte;
  end

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    idx_s      = idx_r;
    stop_cnt_s = stop_cnt_r;
    par_en_s   = par_en_r;
    par_bit_s  = par_bit_r;
    tx_data_s  = tx_data_r;
    ready_s    = ready_r;
    active_s   = active_r;
    done_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        tx_data_s = 1'b1;
        ready_s   = 1'b1;
        active_s  = 1'b0;
        if (i_Tx_Valid && ready_r) begin
          // Word and parity mode are captured here; the frame never looks
          // at the inputs again.
          state_s    = ST_START;
          tx_data_s  = 1'b0;
          ready_s    = 1'b0;
          active_s   = 1'b1;
          shift_s    = i_Tx_Byte;
          idx_s      = '0;
          stop_cnt_s = 1'b0;
          par_en_s   = (i_Parity_Mode != PAR_NONE);
          par_bit_s  = parity_bit(word_ext_s, i_Parity_Mode);
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (bit_end_s) begin
          state_s   = ST_DATA;
          tx_data_s = shift_r[0];
          shift_s   = shift_r >> 1;
          idx_s     = '0;
        end else begin
          state_s = ST_START;
        end
      end

      ST_DATA: begin
        if (bit_end_s) begin
          if (idx_r == LAST_IDX) begin
            if (par_en_r) begin
              state_s   = ST_PARITY;
              tx_data_s = par_bit_r;
            end else begin
              state_s    = ST_STOP;
              tx_data_s  = 1'b1;
              stop_cnt_s = 1'b0;
            end
          end else begin
            tx_data_s = shift_r[0];
            shift_s   = shift_r >> 1;
            idx_s     = idx_r + 1'b1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (bit_end_s) begin
          state_s    = ST_STOP;
          tx_data_s  = 1'b1;
          stop_cnt_s = 1'b0;
        end else begin
          state_s = ST_PARITY;
        end
      end

      ST_STOP: begin
        tx_data_s = 1'b1;
        if (bit_end_s) begin
          if (stop_cnt_r == LAST_STOP) begin
            state_s  = ST_IDLE;
            done_s   = 1'b1;
            ready_s  = 1'b1;
            active_s = 1'b0;
          end else begin
            stop_cnt_s = stop_cnt_r + 1'b1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        tx_data_s = 1'b1;
        ready_s   = 1'b1;
        active_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      idx_r      <= '0;
      stop_cnt_r <= 1'b0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      tx_data_r  <= 1'b1;
      ready_r    <= 1'b1;
      active_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      idx_r      <= idx_s;
      stop_cnt_r <= stop_cnt_s;
      par_en_r   <= par_en_s;
      par_bit_r  <= par_bit_s;
      tx_data_r  <= tx_data_s;
      ready_r    <= ready_s;
      active_r   <= active_s;
      done_r     <= done_s;
    end
  end

  assign o_Tx_Data   = tx_data_r;
  assign o_Tx_Ready  = ready_r;
  assign o_Tx_Active = active_r;
  assign o_Tx_Done   = done_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: randomized and directed bench for uart_tx_param.
// A frame-level reference model (queue of expected line levels per cycle)
// is compared against both DUT instances on every falling clock edge.
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1
  logic [7:0] byte1;
  logic       valid1;
  logic [1:0] mode1;
  logic       ready1, active1, done1, line1;
  // Instance 2: CLKS_PER_BIT=2, DATA_BITS=5, STOP_BITS=2
  logic [4:0] byte2;
  logic       valid2;
  logic [1:0] mode2;
  logic       ready2, active2, done2, line2;

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .i_Tx_Byte(byte1), .i_Tx_Valid(valid1),
    .i_Parity_Mode(mode1), .o_Tx_Ready(ready1), .o_Tx_Active(active1),
    .o_Tx_Done(done1), .o_Tx_Data(line1));

  uart_tx_param #(.CLKS_PER_BIT(2), .DATA_BITS(5), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .i_Tx_Byte(byte2), .i_Tx_Valid(valid2),
    .i_Parity_Mode(mode2), .o_Tx_Ready(ready2), .o_Tx_Active(active2),
    .o_Tx_Done(done2), .o_Tx_Data(line2));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Line level of frame bit 'bi' (0 = start bit) from the framing rules.
  function automatic logic lvl(input int bi, input int d, input logic [8:0] data,
                               input logic [1:0] m);
    int   ones;
    logic r;
    ones = 0;
    for (int i = 0; i < d; i++) ones += int'(data[i]);
    if (bi == 0)                         r = 1'b0;
    else if (bi <= d)                    r = data[bi-1];
    else if (m != 2'b00 && bi == d + 1) begin
      if (m == 2'b10)      r = ((ones % 2) == 1);   // even: total ones even
      else if (m == 2'b01) r = ((ones % 2) == 0);   // odd: total ones odd
      else                 r = 1'b1;                // mark
    end
    else                                 r = 1'b1;  // stop bits
    return r;
  endfunction

  function automatic int nbits(input int d, input int s, input logic [1:0] m);
    return 1 + d + ((m != 2'b00) ? 1 : 0) + s;
  endfunction

  // Reference models: queue holds the expected line level of each future cycle.
  logic q1[$];
  logic q2[$];
  logic ed1 = 1'b0;
  logic ed2 = 1'b0;
  bit   rdy1, rdy2;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        q1.delete(); q2.delete(); ed1 = 1'b0; ed2 = 1'b0;
      end else begin
        rdy1 = (q1.size() == 0);
        ed1  = 1'b0;
        if (q1.size() > 0) begin
          void'(q1.pop_front());
          if (q1.size() == 0) ed1 = 1'b1;
        end
        if (rdy1 && valid1) begin
          for (int b = 0; b < nbits(8, 1, mode1); b++)
            for (int c = 0; c < 4; c++) q1.push_back(lvl(b, 8, {1'b0, byte1}, mode1));
        end
        rdy2 = (q2.size() == 0);
        ed2  = 1'b0;
        if (q2.size() > 0) begin
          void'(q2.pop_front());
          if (q2.size() == 0) ed2 = 1'b1;
        end
        if (rdy2 && valid2) begin
          for (int b = 0; b < nbits(5, 2, mode2); b++)
            for (int c = 0; c < 2; c++) q2.push_back(lvl(b, 5, {4'b0, byte2}, mode2));
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("line1",   int'(line1),   (q1.size() > 0) ? int'(q1[0]) : 1);
      chk("ready1",  int'(ready1),  (q1.size() == 0) ? 1 : 0);
      chk("active1", int'(active1), (q1.size() > 0) ? 1 : 0);
      chk("done1",   int'(done1),   int'(ed1));
      chk("line2",   int'(line2),   (q2.size() > 0) ? int'(q2[0]) : 1);
      chk("ready2",  int'(ready2),  (q2.size() == 0) ? 1 : 0);
      chk("active2", int'(active2), (q2.size() > 0) ? 1 : 0);
      chk("done2",   int'(done2),   int'(ed2));
    end
  end

  // Capture buffers for the literal checks.
  logic ln [0:99];
  logic dn [0:99];
  logic ac [0:99];
  logic rd [0:99];
  logic [9:0] pat_a5 = 10'b1101001010;  // bit i = line level of frame bit i
  logic [7:0] pat_15 = 8'b11101010;

  // Called at a falling edge; returns at the falling edge just after acceptance.
  task automatic start1(input logic [7:0] b, input logic [1:0] m);
    int n;
    n = 0;
    byte1 = b; mode1 = m; valid1 = 1'b1;
    while (ready1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("start1_wait", (n < 200) ? 1 : 0, 1);
    @(negedge clk);
    valid1 = 1'b0;
  endtask

  task automatic start2(input logic [4:0] b, input logic [1:0] m);
    int n;
    n = 0;
    byte2 = b; mode2 = m; valid2 = 1'b1;
    while (ready2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("start2_wait", (n < 200) ? 1 : 0, 1);
    @(negedge clk);
    valid2 = 1'b0;
  endtask

  // Sample instance 1 for n cycles (k=1 is the first cycle after accept),
  // optionally disturbing the inputs mid-frame.
  task automatic cap1(input int n, input int pk, input int code);
    for (int k = 1; k <= n; k++) begin
      ln[k] = line1; dn[k] = done1; ac[k] = active1; rd[k] = ready1;
      if (code == 1 && k == pk)     mode1 = ~mode1;
      if (code == 2 && k == pk)     begin valid1 = 1'b1; byte1 = 8'h3C; end
      if (code == 2 && k == pk + 1) valid1 = 1'b0;
      if (code == 3 && k == 1)      byte1 = 8'hFF;
      if (code == 3 && k == 42)     valid1 = 1'b0;
      if (k < n) @(negedge clk);
    end
  endtask

  task automatic cap2(input int n);
    for (int k = 1; k <= n; k++) begin
      ln[k] = line2; dn[k] = done2; ac[k] = active2; rd[k] = ready2;
      if (k < n) @(negedge clk);
    end
  endtask

  function automatic int first_dn(input int n);
    for (int k = 1; k <= n; k++) if (dn[k]) return k;
    return -1;
  endfunction

  function automatic int cnt_ac(input int lo, input int hi);
    int c;
    c = 0;
    for (int k = lo; k <= hi; k++) c += int'(ac[k]);
    return c;
  endfunction

  task automatic chk_a5_line(input string nm);
    for (int k = 1; k <= 40; k++) chk(nm, int'(ln[k]), int'(pat_a5[(k-1)/4]));
  endtask

  task automatic t3(input logic [1:0] m, input logic ep, input string nm);
    start1(8'hA5, m);
    cap1(52, 12, 1);
    for (int k = 37; k <= 40; k++) chk({nm, "_parity"}, int'(ln[k]), int'(ep));
    chk({nm, "_done_at"}, first_dn(52), 45);
    chk({nm, "_active_cycles"}, cnt_ac(1, 52), 44);
    repeat (2) @(negedge clk);
  endtask

  int dcount;

  initial begin
    valid1 = 1'b0; byte1 = 8'h00; mode1 = 2'b00;
    valid2 = 1'b0; byte2 = 5'h00; mode2 = 2'b00;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_data",   int'(line1),   1);
    chk("rst_ready",  int'(ready1),  1);
    chk("rst_active", int'(active1), 0);
    chk("rst_done",   int'(done1),   0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, no parity
    start1(8'hA5, 2'b00);
    cap1(48, 0, 0);
    chk_a5_line("a5_line");
    chk("a5_done_at", first_dn(48), 41);
    chk("a5_active_cycles", cnt_ac(1, 48), 40);
    repeat (2) @(negedge clk);

    // Parity modes, with mode changed mid-frame
    t3(2'b10, 1'b0, "even");
    t3(2'b01, 1'b1, "odd");
    t3(2'b11, 1'b1, "mark");

    // Back-to-back 0x00 then 0xFF with valid held
    byte1 = 8'h00; mode1 = 2'b00; valid1 = 1'b1;
    @(negedge clk);
    cap1(90, 0, 3);
    dcount = 0;
    for (int k = 1; k <= 81; k++) dcount += int'(rd[k]);
    chk("b2b_ready_cycles", dcount, 1);
    chk("b2b_first_data0", int'(ln[6]), 0);
    chk("b2b_stop", int'(ln[40]), 1);
    chk("b2b_done1", int'(dn[41]), 1);
    chk("b2b_start2", int'(ln[42]), 0);
    chk("b2b_data2", int'(ln[46]), 1);
    chk("b2b_done2", int'(dn[82]), 1);
    repeat (2) @(negedge clk);

    // Valid pulse while busy is ignored
    start1(8'hA5, 2'b00);
    cap1(52, 10, 2);
    chk_a5_line("busy_line");
    chk("busy_done_at", first_dn(52), 41);
    chk("busy_no_second", cnt_ac(42, 52), 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame
    start1(8'h5A, 2'b01);
    repeat (14) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("midrst_data",   int'(line1),   1);
    chk("midrst_ready",  int'(ready1),  1);
    chk("midrst_active", int'(active1), 0);
    @(negedge clk); @(negedge clk);
    #2 reset_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 60; k++) begin @(negedge clk); dcount += int'(done1); end
    chk("midrst_no_done", dcount, 0);

    // Config sweep instance: 0x15, no parity
    start2(5'h15, 2'b00);
    cap2(20);
    for (int k = 1; k <= 16; k++) chk("cfg_line", int'(ln[k]), int'(pat_15[(k-1)/2]));
    chk("cfg_done_at", first_dn(20), 17);
    chk("cfg_active_cycles", cnt_ac(1, 20), 16);
    repeat (2) @(negedge clk);

    // Randomized frames on instance 1; inputs scrambled after each accept
    for (int r = 0; r < 40; r++) begin
      start1(8'($urandom), 2'($urandom_range(0, 3)));
      byte1 = 8'($urandom); mode1 = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    // Randomized frames on instance 2
    for (int r = 0; r < 20; r++) begin
      start2(5'($urandom), 2'($urandom_range(0, 3)));
      byte2 = 5'($urandom); mode2 = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    repeat (60) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
